// File: rtl/uart_rx_fifo_param.sv
// UART receiver with 16x oversampling, configurable frame format and a
// first-word-fall-through RX FIFO whose entries carry parity/framing error tags.
module uart_rx_fifo_param #(
    parameter int C_SYSTEM_FREQ = 50_000_000,
    parameter int C_BAUDRATE    = 57600,
    parameter int C_DATA_BITS   = 8,
    parameter int C_USE_PARITY  = 0,
    parameter int C_ODD_PARITY  = 0,
    parameter int C_STOP_BITS   = 1,
    parameter int C_FIFO_DEPTH  = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          RX,
    input  logic                          Enable_rx,
    input  logic                          rd_uart_en,
    output logic [C_DATA_BITS-1:0]        RX_data,
    output logic                          RX_perr,
    output logic                          RX_ferr,
    output logic                          Empty,
    output logic                          Full,
    output logic [$clog2(C_FIFO_DEPTH):0] Count,
    output logic                          Overrun,
    input  logic                          clr_overrun,
    output logic                          Break_det
);

    localparam int DIV = C_SYSTEM_FREQ / (16 * C_BAUDRATE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(C_FIFO_DEPTH);
    localparam int EW  = C_DATA_BITS + 2;
    localparam logic [AW:0] C_FULL_CNT = (AW + 1)'(C_FIFO_DEPTH);
    localparam logic [3:0]  C_LAST_BIT = 4'(C_DATA_BITS - 1);
    localparam logic        C_LAST_STOP = 1'(C_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic                   w_fall;

    logic [DW-1:0]          r_div;
    logic                   w_tick;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_tick_cnt;
    logic [3:0]             w_tick_next;
    logic [3:0]             r_bit_cnt;
    logic [3:0]             w_bit_next;
    logic                   r_stop_cnt;
    logic                   w_stop_next;
    logic                   r_s7;
    logic                   w_s7_next;
    logic                   r_s8;
    logic                   w_s8_next;
    logic [C_DATA_BITS-1:0] r_shift;
    logic [C_DATA_BITS-1:0] w_shift_next;
    logic                   r_par_bit;
    logic                   w_par_next;
    logic                   r_ferr;
    logic                   w_ferr_next;

    logic                   w_maj;
    logic                   w_frame_ferr;
    logic                   w_frame_perr;
    logic                   w_is_break;
    logic                   w_done;

    logic [EW-1:0]          r_mem [C_FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_overrun;
    logic                   r_break;
    logic                   w_push;
    logic                   w_pop;
    logic [EW-1:0]          w_head;

    // Two-flop synchroniser preset to the idle line level; r_rx_prev gives the falling edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    assign w_tick = (r_div == DW'(DIV - 1));

    // Majority of the samples taken at ticks 7, 8 and the current one at tick 9.
    assign w_maj = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);

    assign w_frame_ferr = r_ferr | ~w_maj;
    assign w_frame_perr = (C_USE_PARITY != 0) &&
                          ((^r_shift ^ r_par_bit) != (C_ODD_PARITY != 0));
    assign w_is_break   = (r_shift == '0) && ((C_USE_PARITY == 0) || !r_par_bit) &&
                          w_frame_ferr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_cnt  <= w_bit_next;
            r_stop_cnt <= w_stop_next;
            r_s7       <= w_s7_next;
            r_s8       <= w_s8_next;
            r_shift    <= w_shift_next;
            r_par_bit  <= w_par_next;
            r_ferr     <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_stop_next  = r_stop_cnt;
        w_s7_next    = r_s7;
        w_s8_next    = r_s8;
        w_shift_next = r_shift;
        w_par_next   = r_par_bit;
        w_ferr_next  = r_ferr;
        w_done       = 1'b0;

        if (!Enable_rx) begin
            w_state_next = S_IDLE;
            w_tick_next  = '0;
        end else begin
            if (w_tick && (r_state inside {S_START, S_DATA, S_PARITY, S_STOP})) begin
                w_tick_next = r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd7) begin
                    w_s7_next = r_rx_sync;
                end
                if (r_tick_cnt == 4'd8) begin
                    w_s8_next = r_rx_sync;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        w_state_next = S_START;
                        w_tick_next  = '0;
                        w_ferr_next  = 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7 && r_rx_sync) begin
                            w_state_next = S_IDLE;
                        end else if (r_tick_cnt == 4'd15) begin
                            w_state_next = S_DATA;
                            w_bit_next   = '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd9) begin
                            w_shift_next = {w_maj, r_shift[C_DATA_BITS-1:1]};
                        end
                        if (r_tick_cnt == 4'd15) begin
                            if (r_bit_cnt == C_LAST_BIT) begin
                                w_state_next = (C_USE_PARITY != 0) ? S_PARITY : S_STOP;
                                w_stop_next  = 1'b0;
                            end else begin
                                w_bit_next = r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd9) begin
                            w_par_next = w_maj;
                        end
                        if (r_tick_cnt == 4'd15) begin
                            w_state_next = S_STOP;
                            w_stop_next  = 1'b0;
                        end
                    end
                end
                S_STOP: begin
                    // The last stop bit ends the frame at its mid-point so a
                    // back-to-back start edge is not missed.
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd9) begin
                            if (r_stop_cnt == C_LAST_STOP) begin
                                w_done       = 1'b1;
                                w_state_next = w_is_break ? S_BRK_WAIT : S_IDLE;
                            end else begin
                                w_ferr_next = w_frame_ferr;
                            end
                        end
                        if (r_tick_cnt == 4'd15) begin
                            w_stop_next = 1'b1;
                        end
                    end
                end
                S_BRK_WAIT: begin
                    if (r_rx_sync) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign w_pop  = rd_uart_en & ~Empty;
    assign w_push = w_done & ~w_is_break & (~Full | w_pop);

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_frame_ferr, w_frame_perr, r_shift};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (clr_overrun) begin
                r_overrun <= 1'b0;
            end else if (w_done && !w_is_break && Full && !w_pop) begin
                r_overrun <= 1'b1;
            end
            r_break <= w_done & w_is_break;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign Empty     = (r_count == '0);
    assign Full      = (r_count == C_FULL_CNT);
    assign Count     = r_count;
    assign Overrun   = r_overrun;
    assign Break_det = r_break;
    assign RX_data   = Empty ? '0 : w_head[C_DATA_BITS-1:0];
    assign RX_perr   = ~Empty & w_head[C_DATA_BITS];
    assign RX_ferr   = ~Empty & w_head[C_DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: two instances (8N1 depth 4, 8E2 depth 8) at 16 clocks/bit,
// frame-level reference model feeding per-instance scoreboards drained by monitors.
module tb_uart_rx_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       en_a = 1'b1, en_b = 1'b1;
    logic       rd_a = 1'b0, rd_b = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       perr_a, perr_b, ferr_a, ferr_b;
    logic       empty_a, empty_b, full_a, full_b;
    logic [2:0] count_a;
    logic [3:0] count_b;
    logic       ov_a, ov_b, brk_a, brk_b;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    int  exp_brk_a = 0, exp_brk_b = 0;
    int  seen_brk_a = 0, seen_brk_b = 0;
    logic exp_ov_a = 1'b0;
    logic auto_rd_a = 1'b1, auto_rd_b = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_param #(
        .C_SYSTEM_FREQ(16_000_000), .C_BAUDRATE(1_000_000), .C_DATA_BITS(8),
        .C_USE_PARITY(0), .C_ODD_PARITY(0), .C_STOP_BITS(1), .C_FIFO_DEPTH(4)
    ) u_dut_a (
        .Clk(clk), .Reset(rst), .RX(rx_a), .Enable_rx(en_a), .rd_uart_en(rd_a),
        .RX_data(data_a), .RX_perr(perr_a), .RX_ferr(ferr_a), .Empty(empty_a),
        .Full(full_a), .Count(count_a), .Overrun(ov_a), .clr_overrun(clr_a),
        .Break_det(brk_a)
    );

    uart_rx_fifo_param #(
        .C_SYSTEM_FREQ(16_000_000), .C_BAUDRATE(1_000_000), .C_DATA_BITS(8),
        .C_USE_PARITY(1), .C_ODD_PARITY(0), .C_STOP_BITS(2), .C_FIFO_DEPTH(8)
    ) u_dut_b (
        .Clk(clk), .Reset(rst), .RX(rx_b), .Enable_rx(en_b), .rd_uart_en(rd_b),
        .RX_data(data_b), .RX_perr(perr_b), .RX_ferr(ferr_b), .Empty(empty_b),
        .Full(full_b), .Count(count_b), .Overrun(ov_b), .clr_overrun(clr_b),
        .Break_det(brk_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever the FIFO presents a head entry.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (auto_rd_a && !empty_a) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_entry_a", {22'd0, ferr_a, perr_a, data_a}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_a.pop_front();
                    $display("[A] pop data=0x%02h perr=%0d ferr=%0d", data_a, perr_a, ferr_a);
                    check("entry_a", {22'd0, ferr_a, perr_a, data_a}, {22'd0, e});
                end
                rd_a = 1'b1;
            end else begin
                rd_a = 1'b0;
            end
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (auto_rd_b && !empty_b) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_entry_b", {22'd0, ferr_b, perr_b, data_b}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_b.pop_front();
                    $display("[B] pop data=0x%02h perr=%0d ferr=%0d", data_b, perr_b, ferr_b);
                    check("entry_b", {22'd0, ferr_b, perr_b, data_b}, {22'd0, e});
                end
                rd_b = 1'b1;
            end else begin
                rd_b = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (brk_a) seen_brk_a++;
            if (brk_b) seen_brk_b++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model works on whole frames: the expected tag/data is
    // derived from the fields sent, then the bits are driven 16 clocks each.
    task automatic send_frame(input int which, input logic [7:0] data, input logic par,
                              input logic [1:0] stops, input int abort_bits,
                              input logic end_level);
        logic bits[$];
        logic ferr, perr, brk, en;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (which == 1) bits.push_back(par);
        bits.push_back(stops[0]);
        if (which == 1) bits.push_back(stops[1]);
        ferr = (which == 0) ? !stops[0] : !(stops[0] && stops[1]);
        perr = (which == 1) ? ((^data) != par) : 1'b0;
        brk  = (data == 8'd0) && (which == 0 || !par) && ferr;
        en   = (which == 0) ? en_a : en_b;
        $display("[%s] send data=0x%02h par=%0d stops=%02b abort=%0d", (which == 0) ? "A" : "B",
                 data, par, stops, abort_bits);
        if (en && abort_bits == 0) begin
            if (brk) begin
                if (which == 0) exp_brk_a++; else exp_brk_b++;
            end else if (which == 0) begin
                if (!auto_rd_a && exp_a.size() >= 4) exp_ov_a = 1'b1;
                else exp_a.push_back({ferr, perr, data});
            end else begin
                exp_b.push_back({ferr, perr, data});
            end
        end
        foreach (bits[i]) begin
            if (abort_bits != 0 && i >= abort_bits) break;
            if (which == 0) rx_a = bits[i]; else rx_b = bits[i];
            repeat (16) @(negedge clk);
        end
        if (which == 0) rx_a = end_level; else rx_b = end_level;
    endtask

    task automatic wait_drain(input int which);
        int n = 0;
        while (n < 800 && ((which == 0) ? (!empty_a || exp_a.size() != 0)
                                        : (!empty_b || exp_b.size() != 0))) begin
            @(negedge clk);
            n++;
        end
        if (which == 0) begin
            check("drain_a_pending", exp_a.size(), 0);
            check("drain_a_empty", empty_a, 1);
        end else begin
            check("drain_b_pending", exp_b.size(), 0);
            check("drain_b_empty", empty_b, 1);
        end
    endtask

    task automatic check_reset_a();
        check("rst_a_empty", empty_a, 1);
        check("rst_a_full", full_a, 0);
        check("rst_a_count", count_a, 0);
        check("rst_a_overrun", ov_a, 0);
        check("rst_a_break", brk_a, 0);
        check("rst_a_data", {perr_a, ferr_a, data_a}, 0);
    endtask

    initial begin
        int cyc;
        int w;
        logic [7:0] d;
        logic p;
        logic [1:0] s;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_a();
        check("rst_b_empty", empty_b, 1);
        check("rst_b_count", count_b, 0);
        check("rst_b_data", {perr_b, ferr_b, data_b}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 and head latency from the start edge
        cyc = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 2'b11, 0, 1'b1);
            begin
                while (empty_a && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        check("latency_a_window", (cyc >= 154 && cyc <= 160), 1);
        wait_drain(0);

        // Even parity: 0x07 with parity 0 is an error, with parity 1 it is good
        send_frame(1, 8'h07, 1'b0, 2'b11, 0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 2'b11, 0, 1'b1);
        wait_drain(1);

        // Framing error, then break held low
        send_frame(0, 8'h3C, 1'b0, 2'b10, 0, 1'b1);
        repeat (4) @(negedge clk);
        wait_drain(0);
        send_frame(0, 8'h00, 1'b0, 2'b00, 0, 1'b0);
        repeat (48) @(negedge clk);
        check("break_a_count", count_a, 0);
        check("break_a_pulses", seen_brk_a, exp_brk_a);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 8'h81, 1'b0, 2'b11, 0, 1'b1);
        wait_drain(0);
        send_frame(1, 8'h00, 1'b0, 2'b00, 0, 1'b0);
        repeat (40) @(negedge clk);
        rx_b = 1'b1;
        repeat (20) @(negedge clk);
        check("break_b_pulses", seen_brk_b, exp_brk_b);
        send_frame(1, 8'h00, 1'b1, 2'b01, 0, 1'b1);
        wait_drain(1);

        // Overrun with depth 4
        auto_rd_a = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11, 0, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_a_full", full_a, 1);
        check("ovr_a_count", count_a, 4);
        check("ovr_a_overrun", ov_a, exp_ov_a);
        auto_rd_a = 1'b1;
        wait_drain(0);
        check("ovr_a_full_after", full_a, 0);
        check("ovr_a_sticky", ov_a, exp_ov_a);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        exp_ov_a = 1'b0;
        check("ovr_a_cleared", ov_a, exp_ov_a);

        // Short glitch is rejected; then three back-to-back frames
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_a_count", count_a, 0);
        for (int i = 0; i < 3; i++) send_frame(0, 8'h55, 1'b0, 2'b11, 0, 1'b1);
        wait_drain(0);

        // Receiver disabled: line activity ignored
        en_b = 1'b0;
        send_frame(1, 8'h5A, 1'b0, 2'b11, 0, 1'b1);
        repeat (20) @(negedge clk);
        en_b = 1'b1;
        check("disabled_b_count", count_b, 0);

        // Reset mid-frame with a stored entry: everything discarded
        auto_rd_a = 1'b0;
        send_frame(0, 8'h33, 1'b0, 2'b11, 0, 1'b1);
        repeat (4) @(negedge clk);
        check("prerst_a_count", count_a, 1);
        send_frame(0, 8'h81, 1'b0, 2'b11, 5, 1'b1);
        rst = 1'b1;
        exp_a.delete();
        exp_ov_a = 1'b0;
        @(negedge clk);
        check_reset_a();
        repeat (20) @(negedge clk);
        rst = 1'b0;
        auto_rd_a = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(0, 8'h81, 1'b0, 2'b11, 0, 1'b1);
        wait_drain(0);

        // Randomised frames on both instances
        for (int k = 0; k < 24; k++) begin
            w = $urandom_range(0, 1);
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            p = ^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = 2'b11;
            if ($urandom_range(0, 5) == 0) s[$urandom_range(0, 1)] = 1'b0;
            send_frame(w, d, p, s, 0, 1'b1);
            repeat ($urandom_range(3, 20)) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        wait_drain(0);
        wait_drain(1);
        check("final_brk_a", seen_brk_a, exp_brk_a);
        check("final_brk_b", seen_brk_b, exp_brk_b);
        check("final_ov_b", ov_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
